fp_square: RTL and testbench

- Iterative IEEE-754 single-precision squarer; the inverse companion to squareroot.
- Uses the same EN/rdy handshake and operand/result style, so the two can be chained for round-trip checks.
- Sign-preserving to match squareroot's signed convention: result = a*|a|, so square(-x) is negative.
- Shift-add multiplier on the 24-bit mantissa, followed by normalize, round-to-nearest-even and special-case resolution.

---
 rtl/fp_square_if.sv | 11 +
 rtl/fp_square.sv | 143 ++++++++++++++
 tb/tb_fp_square.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_square_if.sv
// Request/result bundle for fp_square: EN/a in, rdy/sq out.
// Uses the same signal names as squareroot so the two can be chained.
interface fp_square_if;
    logic        EN;
    logic [31:0] a;
    logic        rdy;
    logic [31:0] sq;

    modport master (output EN, a, input rdy, sq);
    modport slave  (input EN, a, output rdy, sq);
endinterface

// File: rtl/fp_square.sv
// Iterative IEEE-754 single-precision sign-preserving squarer (sq = a*|a|).
// Shift-add mantissa multiply, then one normalize/round/range cycle; denormals flush to zero.
module fp_square #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    fp_square_if.slave  bus
);

    localparam int         STEPS = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST  = 5'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_sq;
    logic        r_rdy;
    logic [47:0] r_mcand;
    logic [47:0] r_acc;
    logic [23:0] r_mplier;
    logic [4:0]  r_cnt;

    logic        w_capture;
    logic        w_special;
    logic [31:0] w_specialSq;
    logic [47:0] w_accNext;

    // A differing operand while results are shown counts as a fresh request.
    assign w_capture   = bus.EN && ((r_state == IDLE) || ((r_state == DONE) && (bus.a != r_a)));
    assign w_special   = (bus.a[30:23] == 8'h00) || (bus.a[30:23] == 8'hFF);
    assign w_specialSq = (bus.a[30:23] == 8'h00) ? {bus.a[31], 31'b0} : bus.a;

    always_comb begin
        w_accNext = r_acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_accNext = w_accNext + (r_mcand << j);
            end
        end
    end

    logic               w_hi;
    logic [23:0]        w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_inc;
    logic [24:0]        w_rounded;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_eBase;
    logic signed [9:0]  w_eOut;
    logic [31:0]        w_normSq;

    // Product lies in [1,4): bit 47 selects the extra exponent step.
    always_comb begin
        w_hi    = r_acc[47];
        w_eBase = $signed({2'b00, r_a[30:23]});
        if (w_hi) begin
            w_mant   = r_acc[47:24];
            w_guard  = r_acc[23];
            w_sticky = |r_acc[22:0];
            w_eOut   = (w_eBase <<< 1) - 10'sd126;
        end else begin
            w_mant   = r_acc[46:23];
            w_guard  = r_acc[22];
            w_sticky = |r_acc[21:0];
            w_eOut   = (w_eBase <<< 1) - 10'sd127;
        end
        w_inc     = w_guard & (w_sticky | w_mant[0]);
        w_rounded = {1'b0, w_mant} + {24'b0, w_inc};
        if (w_rounded[24]) begin
            w_frac = 23'd0;
            w_eOut = w_eOut + 10'sd1;
        end else begin
            w_frac = w_rounded[22:0];
        end
        if (w_eOut >= 10'sd255) begin
            w_normSq = {r_a[31], 8'hFF, 23'd0};
        end else if (w_eOut <= 10'sd0) begin
            w_normSq = {r_a[31], 31'b0};
        end else begin
            w_normSq = {r_a[31], w_eOut[7:0], w_frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= 32'd0;
            r_sq     <= 32'd0;
            r_rdy    <= 1'b0;
            r_mcand  <= 48'd0;
            r_acc    <= 48'd0;
            r_mplier <= 24'd0;
            r_cnt    <= 5'd0;
        end else if (w_capture) begin
            r_a   <= bus.a;
            r_rdy <= 1'b0;
            if (w_special) begin
                r_sq    <= w_specialSq;
                r_state <= DONE;
            end else begin
                r_mcand  <= {24'd0, 1'b1, bus.a[22:0]};
                r_mplier <= {1'b1, bus.a[22:0]};
                r_acc    <= 48'd0;
                r_cnt    <= 5'd0;
                r_state  <= CALC;
            end
        end else begin
            case (r_state)
                IDLE: r_rdy <= 1'b0;
                CALC: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == LAST) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_sq    <= w_normSq;
                    r_rdy   <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    if (!bus.EN) begin
                        r_rdy   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rdy = r_rdy;
    assign bus.sq  = r_sq;

endmodule

// File: tb/tb_fp_square.sv
// Directed bench for fp_square: latency, arithmetic, specials, range, handshake, reset.
// Expected values are hand-computed IEEE-754 squares with the input sign kept.
module tb_fp_square;

    logic clk = 1'b0;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;

    fp_square_if bus ();

    fp_square #(.BITS_PER_CYCLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] av);
        bus.EN = en;
        bus.a  = av;
    endtask

    task automatic returnToIdle();
        applyStimulus(1'b0, bus.a);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0);
        repeat (3) tick();
        nCompared++;
        if (bus.rdy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_rdy: got %b want 0", bus.rdy);
        end
        nCompared++;
        if (bus.sq !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_sq: got %h want 00000000", bus.sq);
        end
        rst = 1'b0;
        tick();
        nCompared++;
        if (bus.rdy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL idle_rdy: got %b want 0", bus.rdy);
        end
    endtask

    task automatic test_normal();
        logic [31:0] vecA   [7] = '{32'h3fc00000, 32'hbfc00000, 32'h3fb504f3, 32'h5f7fffff,
                                    32'h5f800000, 32'h1f800000, 32'h40000000};
        logic [31:0] vecExp [7] = '{32'h40100000, 32'hc0100000, 32'h3fffffff, 32'h7f7ffffe,
                                    32'h7f800000, 32'h00000000, 32'h40800000};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, vecA[i]);
            repeat (25) tick();
            nCompared++;
            if (bus.rdy !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL normal_early_rdy[%0d]: got %b want 0 at edge 25", i, bus.rdy);
            end
            tick();
            nCompared++;
            if (bus.rdy !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL normal_rdy[%0d]: got %b want 1 at edge 26", i, bus.rdy);
            end
            nCompared++;
            if (bus.sq !== vecExp[i]) begin
                nMismatched++;
                $display("[TB] FAIL normal_sq[%0d] a=%h: got %h want %h", i, vecA[i], bus.sq, vecExp[i]);
            end
            returnToIdle();
        end
    endtask

    task automatic test_specials();
        logic [31:0] vecA   [5] = '{32'h00000000, 32'h00000001, 32'h7f800000, 32'h7fffffff, 32'hff800000};
        logic [31:0] vecExp [5] = '{32'h00000000, 32'h00000000, 32'h7f800000, 32'h7fffffff, 32'hff800000};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecA[i]);
            tick();
            nCompared++;
            if (bus.rdy !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL special_early_rdy[%0d]: got %b want 0 at edge 1", i, bus.rdy);
            end
            tick();
            nCompared++;
            if (bus.rdy !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL special_rdy[%0d]: got %b want 1 at edge 2", i, bus.rdy);
            end
            nCompared++;
            if (bus.sq !== vecExp[i]) begin
                nMismatched++;
                $display("[TB] FAIL special_sq[%0d] a=%h: got %h want %h", i, vecA[i], bus.sq, vecExp[i]);
            end
            returnToIdle();
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 32'h3fc00000);
        repeat (26) tick();
        nCompared++;
        if (bus.rdy !== 1'b1 || bus.sq !== 32'h40100000) begin
            nMismatched++;
            $display("[TB] FAIL b2b_first: got rdy=%b sq=%h want rdy=1 sq=40100000", bus.rdy, bus.sq);
        end
        repeat (3) tick();
        nCompared++;
        if (bus.rdy !== 1'b1 || bus.sq !== 32'h40100000) begin
            nMismatched++;
            $display("[TB] FAIL b2b_hold: got rdy=%b sq=%h want rdy=1 sq=40100000", bus.rdy, bus.sq);
        end
        applyStimulus(1'b1, 32'h40000000);
        tick();
        nCompared++;
        if (bus.rdy !== 1'b0 || bus.sq !== 32'h40100000) begin
            nMismatched++;
            $display("[TB] FAIL b2b_recapture: got rdy=%b sq=%h want rdy=0 sq=40100000", bus.rdy, bus.sq);
        end
        repeat (24) tick();
        nCompared++;
        if (bus.rdy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_early_rdy: got %b want 0 at edge 25", bus.rdy);
        end
        tick();
        nCompared++;
        if (bus.rdy !== 1'b1 || bus.sq !== 32'h40800000) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second: got rdy=%b sq=%h want rdy=1 sq=40800000", bus.rdy, bus.sq);
        end
    endtask

    task automatic test_drop_en();
        applyStimulus(1'b0, 32'h40000000);
        tick();
        nCompared++;
        if (bus.rdy !== 1'b0 || bus.sq !== 32'h40800000) begin
            nMismatched++;
            $display("[TB] FAIL drop_en: got rdy=%b sq=%h want rdy=0 sq=40800000", bus.rdy, bus.sq);
        end
        repeat (2) tick();
        nCompared++;
        if (bus.rdy !== 1'b0 || bus.sq !== 32'h40800000) begin
            nMismatched++;
            $display("[TB] FAIL drop_en_idle: got rdy=%b sq=%h want rdy=0 sq=40800000", bus.rdy, bus.sq);
        end
    endtask

    task automatic test_ignore_a();
        applyStimulus(1'b1, 32'h3fc00000);
        repeat (5) tick();
        bus.a = 32'h40000000;
        repeat (21) tick();
        nCompared++;
        if (bus.rdy !== 1'b1 || bus.sq !== 32'h40100000) begin
            nMismatched++;
            $display("[TB] FAIL ignore_a: got rdy=%b sq=%h want rdy=1 sq=40100000", bus.rdy, bus.sq);
        end
        applyStimulus(1'b0, 32'h3fc00000);
        tick();
        tick();
    endtask

    task automatic test_reset_mid_calc();
        applyStimulus(1'b1, 32'h3fc00000);
        repeat (9) tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        nCompared++;
        if (bus.rdy !== 1'b0 || bus.sq !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset: got rdy=%b sq=%h want rdy=0 sq=00000000", bus.rdy, bus.sq);
        end
        tick();
        rst = 1'b0;
        repeat (25) tick();
        nCompared++;
        if (bus.rdy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_early_rdy: got %b want 0 at edge 25", bus.rdy);
        end
        tick();
        nCompared++;
        if (bus.rdy !== 1'b1 || bus.sq !== 32'h40100000) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_result: got rdy=%b sq=%h want rdy=1 sq=40100000", bus.rdy, bus.sq);
        end
        returnToIdle();
    endtask

    initial begin
        $display("[TB] starting fp_square directed tests");
        test_reset();
        test_normal();
        test_specials();
        test_back_to_back();
        test_drop_en();
        test_ignore_a();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
